// File: rtl/inst_enc_pkg.sv
// Shared constants and types for the RV32I instruction encoder.
package inst_enc_pkg;

  localparam logic [2:0] FMT_R      = 3'd0;
  localparam logic [2:0] FMT_I      = 3'd1;
  localparam logic [2:0] FMT_ISHIFT = 3'd2;
  localparam logic [2:0] FMT_S      = 3'd3;
  localparam logic [2:0] FMT_B      = 3'd4;
  localparam logic [2:0] FMT_U      = 3'd5;
  localparam logic [2:0] FMT_J      = 3'd6;
  localparam logic [2:0] FMT_ILL    = 3'd7;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } enc_word_t;

  // True when v[31:lsb] is all zeros or all ones (value fits a signed field).
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] s;
    s = 32'($signed(v) >>> lsb);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_imm_packer.sv
// Scatters an immediate into its RV32I bit positions and flags out-of-range values.
module imm_packer
  import inst_enc_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [31:0] imm_i,
  output logic [6:0]  imm_hi_o,
  output logic [4:0]  imm_mid_o,
  output logic [19:0] imm_u_o,
  output logic [4:0]  imm_lo_o,
  output logic        range_err_o
);

  always_comb begin
    imm_hi_o    = imm_i[11:5];
    imm_mid_o   = imm_i[4:0];
    imm_lo_o    = imm_i[4:0];
    imm_u_o     = imm_i[31:12];
    range_err_o = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: range_err_o = !fits_signed(imm_i, 11);
      FMT_ISHIFT:   range_err_o = |imm_i[31:5];
      FMT_B: begin
        imm_hi_o    = {imm_i[12], imm_i[10:5]};
        imm_lo_o    = {imm_i[4:1], imm_i[11]};
        range_err_o = !fits_signed(imm_i, 12) || imm_i[0];
      end
      FMT_U:        range_err_o = |imm_i[11:0];
      FMT_J: begin
        imm_u_o     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12]};
        range_err_o = !fits_signed(imm_i, 20) || imm_i[0];
      end
      FMT_ILL:      range_err_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with an address-tagging counter.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky
);

  logic [6:0]  imm_hi;
  logic [4:0]  imm_mid, imm_lo;
  logic [19:0] imm_u;
  logic        range_err;

  imm_packer u_imm_packer (
    .fmt_i       (fmt),
    .imm_i       (imm),
    .imm_hi_o    (imm_hi),
    .imm_mid_o   (imm_mid),
    .imm_u_o     (imm_u),
    .imm_lo_o    (imm_lo),
    .range_err_o (range_err)
  );

  enc_word_t         enc_d, s1_q, s2_q;
  logic              s1_valid_q, s2_valid_q, err_sticky_q;
  logic [ADDR_W-1:0] s1_addr_q, s2_addr_q, next_addr_q, next_addr_d, tag_addr;
  logic              s2_load, accept, handoff;

  always_comb begin
    enc_d.err  = range_err;
    enc_d.inst = '0;
    case (fmt)
      FMT_R:        enc_d.inst = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:        enc_d.inst = {imm_hi, imm_mid, rs1, funct3, rd, opcode};
      FMT_ISHIFT:   enc_d.inst = {funct7, imm_mid, rs1, funct3, rd, opcode};
      FMT_S, FMT_B: enc_d.inst = {imm_hi, rs2, rs1, funct3, imm_lo, opcode};
      FMT_U, FMT_J: enc_d.inst = {imm_u, rd, opcode};
      default:      enc_d.inst = '0;
    endcase
  end

  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;
  assign handoff  = s2_valid_q && out_ready;

  // A same-cycle addr_load retags the accepted word itself, not just the next one.
  always_comb begin
    tag_addr    = addr_load ? base_addr : next_addr_q;
    next_addr_d = next_addr_q;
    if (accept)         next_addr_d = tag_addr + ADDR_W'(4);
    else if (addr_load) next_addr_d = base_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s1_q         <= '0;
      s2_q         <= '0;
      s1_addr_q    <= '0;
      s2_addr_q    <= '0;
      next_addr_q  <= RST_ADDR;
      err_sticky_q <= 1'b0;
    end else begin
      next_addr_q <= next_addr_d;
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_q      <= enc_d;
          s1_addr_q <= tag_addr;
        end
      end
      // Payload only moves with a real word so out_* never shows stale bubbles.
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_q      <= s1_q;
          s2_addr_q <= s1_addr_q;
        end
      end
      if (handoff && s2_q.err) err_sticky_q <= 1'b1;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_inst   = s2_q.inst;
  assign out_err    = s2_q.err;
  assign out_addr   = s2_addr_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Random + directed bench for inst_encoder against a bit-arithmetic reference model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, addr_load = 1'b0, out_ready = 1'b1;
  logic [2:0]  fmt = '0, funct3 = '0;
  logic [6:0]  opcode = '0, funct7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0, base_addr = '0;

  logic        in_ready, out_valid, out_err, err_sticky;
  logic [31:0] out_inst, out_addr;
  logic        n_in_ready, n_out_valid, n_out_err, n_err_sticky;
  logic [31:0] n_out_inst;
  logic [3:0]  n_out_addr;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(32), .RST_ADDR(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .addr_load(addr_load), .base_addr(base_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky)
  );

  inst_encoder #(.ADDR_W(4), .RST_ADDR(4'h0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .addr_load(addr_load), .base_addr(base_addr[3:0]),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_inst(n_out_inst),
    .out_addr(n_out_addr), .out_err(n_out_err), .err_sticky(n_err_sticky)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void ref_enc(input bit [2:0] f, input bit [6:0] op, input bit [4:0] d,
                                  input bit [4:0] s1, input bit [4:0] s2, input bit [2:0] f3,
                                  input bit [6:0] f7, input bit [31:0] im,
                                  output bit [31:0] inst, output bit err);
    int s;
    bit [31:0] base;
    s    = int'(im);
    base = (32'(f3) << 12) | 32'(op);
    case (f)
      3'd0: begin inst = (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(d) << 7) | base; err = 0; end
      3'd1: begin inst = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(d) << 7) | base;
                  err = (s < -2048) || (s > 2047); end
      3'd2: begin inst = (32'(f7) << 25) | ((im & 32'h1F) << 20) | (32'(s1) << 15) | (32'(d) << 7) | base;
                  err = im > 32'd31; end
      3'd3: begin inst = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | ((im & 32'h1F) << 7) | base;
                  err = (s < -2048) || (s > 2047); end
      3'd4: begin inst = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                       | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7) | base;
                  err = (s < -4096) || (s > 4095) || (im[0] == 1'b1); end
      3'd5: begin inst = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
                  err = (im & 32'hFFF) != 0; end
      3'd6: begin inst = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 1) << 20)
                       | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'(op);
                  err = (s < -(1 << 20)) || (s >= (1 << 20)) || (im[0] == 1'b1); end
      default: begin inst = 0; err = 1; end
    endcase
  endfunction

  typedef struct { bit [31:0] inst; bit [31:0] addr; bit err; int cyc; } exp_t;
  exp_t      q[$];
  bit [31:0] next_m = 0;
  bit        sticky_m = 0;
  int        cyc = 0, n_acc = 0;

  // Reference model: words in flight are the queue; a word is visible two samples after acceptance.
  always @(negedge clk) begin
    exp_t e;
    bit   ov;
    cyc++;
    chk("err_sticky", err_sticky, sticky_m);
    chk("err_sticky_n", n_err_sticky, sticky_m);
    chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
    chk("in_ready_n", n_in_ready, !(q.size() == 2 && !out_ready));
    ov = (q.size() > 0) && (cyc - q[0].cyc >= 2);
    chk("out_valid", out_valid, ov);
    chk("out_valid_n", n_out_valid, ov);
    if (!rst_n) begin
      q.delete();
      next_m   = 0;
      sticky_m = 0;
    end else begin
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("out_inst", out_inst, e.inst);
        chk("out_addr", out_addr, e.addr);
        chk("out_err", out_err, e.err);
        chk("out_inst_n", n_out_inst, e.inst);
        chk("out_addr_n", n_out_addr, e.addr[3:0]);
        if (e.err) sticky_m = 1;
      end
      if (in_valid && in_ready) begin
        ref_enc(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, e.inst, e.err);
        e.addr = addr_load ? base_addr : next_m;
        next_m = e.addr + 4;
        e.cyc  = cyc;
        q.push_back(e);
        n_acc++;
      end else if (addr_load) begin
        next_m = base_addr;
      end
    end
  end

  task automatic push(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im,
                      input logic ld, input logic [31:0] base);
    fmt = f; opcode = op; rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7 = f7; imm = im;
    addr_load = ld; base_addr = base; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; addr_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] edges [14];
    edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095, -32'sd4096,
              -32'sd4098, 32'd31, 32'd32, 32'h000FFFFE, 32'h00100000, -32'sd1048576, 32'h0};
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 63)) - 32'd32;
      1: return edges[$urandom_range(0, 13)];
      2: return $urandom;
      3: return $urandom & 32'hFFFFF000;
      4: return 32'($urandom_range(0, 40));
      default: return 32'($urandom_range(0, 10000)) - 32'd5000;
    endcase
  endfunction

  initial begin
    int acc0;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // addi x1,x0,-1 with latency check
    push(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0, 32'h0);
    @(negedge clk);
    chk("t1_lat_n1", out_valid, 0);
    @(negedge clk);
    chk("t1_lat_n2", out_valid, 1);
    chk("t1_inst", out_inst, 32'hFFF00093);
    chk("t1_err", out_err, 0);
    @(posedge clk); #1;

    push(3'd4, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1'b0, 32'h0);
    push(3'd6, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1'b0, 32'h0);
    @(negedge clk);
    chk("t2_b_inst", out_inst, 32'hFE208EE3);
    @(negedge clk);
    chk("t2_j_inst", out_inst, 32'h001000EF);
    idle(1);

    push(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t3_inst", out_inst, 32'h80000093);
    chk("t3_err", out_err, 1);
    @(negedge clk);
    chk("t3_sticky", err_sticky, 1);
    @(posedge clk); #1;
    push(3'd4, 7'b1100011, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 32'd6, 1'b0, 32'h0);
    push(3'd4, 7'b1100011, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 32'd5, 1'b0, 32'h0);
    @(negedge clk);
    chk("t3_b6_err", out_err, 0);
    @(negedge clk);
    chk("t3_b5_err", out_err, 1);
    idle(2);

    // backpressure from a clean address counter
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    out_ready = 1'b0;
    acc0 = n_acc;
    fmt = 3'd0; opcode = 7'b0110011; rd = 5'd5; rs1 = 5'd6; rs2 = 5'd7; funct3 = 3'd0; funct7 = 7'd0;
    in_valid = 1'b1;
    idle(3);
    @(negedge clk);
    chk("t4_accepted", n_acc - acc0, 2);
    chk("t4_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    idle(4);
    push(3'd5, 7'b0110111, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_addr3", out_addr, 32'h8);
    @(posedge clk); #1;

    push(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0, 1'b1, 32'h10C);
    push(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t5_addr_load", out_addr, 32'h10C);
    chk("t5_addr_load_n", n_out_addr, 4'hC);
    @(negedge clk);
    chk("t5_addr_next", out_addr, 32'h110);
    chk("t5_wrap_n", n_out_addr, 4'h0);
    @(posedge clk); #1;

    // mid-stream reset with both stages full and the sticky flag set
    push(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, 1'b0, 32'h0);
    idle(3);
    @(negedge clk);
    chk("t6_sticky_set", err_sticky, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(3'd1, 7'b0000011, 5'd2, 5'd3, 5'd0, 3'd2, 7'd0, 32'd8, 1'b0, 32'h0);
    push(3'd3, 7'b0100011, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 32'd12, 1'b0, 32'h0);
    @(negedge clk);
    chk("t6_full", out_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    @(negedge clk);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_sticky", err_sticky, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_out_inst", out_inst, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(3'd0, 7'b0110011, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_addr", out_addr, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 2000; i++) begin
      rst_n     = ($urandom_range(0, 499) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      addr_load = ($urandom_range(0, 19) == 0);
      base_addr = $urandom & 32'hFFFFFFFC;
      fmt       = 3'($urandom_range(0, 7));
      opcode    = 7'($urandom);
      rd        = 5'($urandom);
      rs1       = 5'($urandom);
      rs2       = 5'($urandom);
      funct3    = 3'($urandom);
      funct7    = 7'($urandom);
      imm       = rand_imm();
      @(posedge clk); #1;
    end

    rst_n = 1'b1; in_valid = 1'b0; addr_load = 1'b0; out_ready = 1'b1;
    idle(5);
    @(negedge clk);
    chk("drain_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
